sdspi_cmd_responder: RTL and testbench
======================================

# sdspi_cmd_responder

Card-side counterpart of the host SPI command issuer. It sits above a byte-level SPI slave, which handles MOSI and MISO serialisation. It frames 6-byte SD commands from the MOSI byte stream, checks CRC7, and hands {cmd, arg} to a card-model handler. It then serialises the handler's R1, R1b, R3 or R7 response back onto MISO with the required Ncr gap and busy signalling.

## Interface
- NCR, 1: filler 0xFF bytes between the CRC byte and R1. Legal range 1..8.
- OPT_CRC, 1: when 1, check CRC7 and the stop bit. When 0, ignore them and hold o_cmd_crc_err at 0.
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_ll_stb  in  1  one-cycle pulse: one SPI byte transfer has completed
- i_ll_byte  in  8  MOSI byte received; valid with i_ll_stb
- o_ll_byte  out  8  MISO byte for the next transfer. Lower level samples it at least 2 clocks after i_ll_stb.
- o_cmd_stb  out  1  one-cycle pulse: a command has been received
- o_cmd  out  6  command index
- o_cmd_arg  out  32  command argument, MSB first as received
- o_cmd_crc_err  out  1  received CRC7 or stop bit was wrong. Registered with o_cmd_stb but with no pulse (see Operation).
- i_rsp_valid  in  1  handler response present. Accepted only in state WAIT.
- i_rsp_type  in  2  00 = R1, 01 = R1b, 1x = R3/R7
- i_rsp_r1  in  8  R1 byte
- i_rsp_data  in  32  R3/R7 payload
- i_busy_hold  in  1  R1b: card is busy; MISO sends 0x00 bytes while high
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, ARG, CRC, WAIT, R1, DATA, BUSY. Every transition is qualified by i_ll_stb except the capture of i_rsp_valid.
- IDLE: a byte with bits [7:6] == 2'b01 latches o_cmd = byte[5:0] and enters ARG with count 4. All other bytes are ignored.
- ARG: shifts 4 bytes into o_cmd_arg MSB first, then enters CRC.
- CRC: compares the byte to {crc7, 1'b1}, where crc7 covers the 40 command bits and uses polynomial x^7 + x^3 + 1. Then enters WAIT with ncr_cnt = NCR.
  - CRC good or OPT_CRC = 0: o_cmd_stb pulses the next clock.
  - CRC bad: no o_cmd_stb. o_cmd_crc_err = 1, and the response is forced internally to R1 = 8'h08 (type R1).
- WAIT: o_ll_byte = 0xFF. i_rsp_valid is latched once into rsp_type, rsp_r1 and rsp_data. Each stb decrements ncr_cnt, saturating at 0.
  - On an stb where ncr_cnt ≤ 1 and a response is latched (including one arriving in the same cycle): o_ll_byte <= r1 and go to R1.
  - No timeout: filler 0xFF bytes continue until the handler responds.
- R1, on stb, by response type:
  - R1: o_ll_byte <= 0xFF, go to IDLE.
  - R3/R7: o_ll_byte <= data[31:24], count 3, go to DATA.
  - R1b with i_busy_hold high: o_ll_byte <= 0x00, go to BUSY.
  - R1b with i_busy_hold low: o_ll_byte <= 0xFF, go to IDLE.
- DATA: each stb outputs the next lower data byte. After the last one is loaded, the next stb sets 0xFF and goes to IDLE.
- BUSY: each stb sets o_ll_byte = i_busy_hold ? 0x00 : 0xFF. It goes to IDLE on the first stb where i_busy_hold is low.
- MOSI content in WAIT, R1, DATA and BUSY is ignored; there is no abort mid-response.

## Timing
- Reset values: state IDLE, o_ll_byte 8'hFF, o_cmd_stb 0, o_cmd 0, o_cmd_arg 0, o_cmd_crc_err 0, o_busy 0, response latch empty.
- All outputs are registered. o_ll_byte updates on the clock after i_ll_stb.
- o_cmd_stb fires exactly 1 clock after the CRC-byte stb. o_cmd, o_cmd_arg and o_cmd_crc_err are stable from then until the next command.
- With a response ready before the first WAIT stb, MISO per transfer after the CRC byte is: NCR × 0xFF, then R1, then the payload or busy bytes, then 0xFF.
- i_rsp_valid outside WAIT, or after the response is latched, is ignored. An i_ll_stb coincident with reset is dropped.
- Reset mid-frame or mid-response returns the block to IDLE and sets o_ll_byte to 0xFF the next clock.

## Structure
- Shared package holds: the state enum, CRC7 polynomial 7'h09, response type codes, R1 error constant 8'h08, and frame start bits 2'b01.
- Sub-module sdspi_crc7_byte: registered byte-wide CRC7 update with clear and enable, also reusable by the host side.

## Test plan
- CMD0, arg 0, CRC 0x95, handler returns R1 0x01 in WAIT, NCR = 1: o_cmd_stb with cmd 0, arg 0, crc_err 0. MISO after the CRC byte is FF, 01, FF.
- CMD8, arg 0x000001AA, CRC 0x87, R7 with r1 0x01 and data 0x000001AA: MISO is FF, 01, 00, 00, 01, AA, FF.
- CMD0, arg 0, CRC 0x97, OPT_CRC = 1: no o_cmd_stb, o_cmd_crc_err = 1, MISO is FF, 08, FF. Repeat with OPT_CRC = 0: o_cmd_stb fires and crc_err = 0.
- R1b with r1 0x00 and i_busy_hold high for 3 transfers: MISO is FF, 00, 00, 00, 00, FF. o_busy falls after the FF is loaded.
- Handler delayed 5 transfers with NCR = 2: MISO is FF×5, then R1. Noise bytes 0xFF and 0x3F in IDLE (bits [7:6] ≠ 01) start no frame.
- Reset asserted during DATA: next clock o_ll_byte = FF, o_busy = 0. A following CMD0 frame is handled normally.

Source files
------------

// File: rtl/sdspi_cmd_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : sdspi_cmd_responder_pkg
// Desc   : Shared types and constants for the card-side SD SPI command
//          responder and the reusable byte-wide CRC7 engine.
// Rev    : 1.0 - initial release
// ============================================================================
package sdspi_cmd_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARG  = 3'd1,
    ST_CRC  = 3'd2,
    ST_WAIT = 3'd3,
    ST_R1   = 3'd4,
    ST_DATA = 3'd5,
    ST_BUSY = 3'd6
  } state_e;

  // x^7 + x^3 + 1
  localparam logic [6:0] CRC7_POLY   = 7'h09;

  // Response type codes; any code with bit 1 set carries a 32-bit payload
  localparam logic [1:0] RSP_R1      = 2'b00;
  localparam logic [1:0] RSP_R1B     = 2'b01;
  localparam int         RSP_DATA_BIT = 1;

  localparam logic [7:0] R1_CRC_ERR  = 8'h08;
  localparam logic [1:0] FRAME_START = 2'b01;
  localparam logic [7:0] FILL_BYTE   = 8'hFF;
  localparam logic [7:0] BUSY_BYTE   = 8'h00;

  // Folds one byte, MSB first, into a running CRC7
  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdspi_cmd_responder_if.sv
`default_nettype none
// ============================================================================
// Module : sdspi_cmd_responder_if
// Desc   : Byte link, command hand-off and response bundle between the
//          responder (slave side) and its lower level / card handler.
// Rev    : 1.0 - initial release
// ============================================================================
interface sdspi_cmd_responder_if;
  logic        i_ll_stb;
  logic [7:0]  i_ll_byte;
  logic [7:0]  o_ll_byte;
  logic        o_cmd_stb;
  logic [5:0]  o_cmd;
  logic [31:0] o_cmd_arg;
  logic        o_cmd_crc_err;
  logic        i_rsp_valid;
  logic [1:0]  i_rsp_type;
  logic [7:0]  i_rsp_r1;
  logic [31:0] i_rsp_data;
  logic        i_busy_hold;
  logic        o_busy;

  modport slave (
    input  i_ll_stb, i_ll_byte, i_rsp_valid, i_rsp_type, i_rsp_r1, i_rsp_data, i_busy_hold,
    output o_ll_byte, o_cmd_stb, o_cmd, o_cmd_arg, o_cmd_crc_err, o_busy
  );

  modport master (
    output i_ll_stb, i_ll_byte, i_rsp_valid, i_rsp_type, i_rsp_r1, i_rsp_data, i_busy_hold,
    input  o_ll_byte, o_cmd_stb, o_cmd, o_cmd_arg, o_cmd_crc_err, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/sdspi_crc7_byte.sv
`default_nettype none
// ============================================================================
// Module : sdspi_crc7_byte
// Desc   : Registered byte-wide CRC7 accumulator. With i_en the byte is folded
//          in; i_clear together with i_en restarts from a zero seed, i_clear
//          alone just zeroes the register.
// Rev    : 1.0 - initial release
// ============================================================================
module sdspi_crc7_byte
  import sdspi_cmd_responder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [6:0] o_crc
);

  logic [6:0] crc_q;

  // Accumulate CRC over enabled bytes, seeding from zero on clear
  always_ff @(posedge i_clk) begin
    if (i_reset)      crc_q <= 7'h00;
    else if (i_en)    crc_q <= crc7_byte(i_clear ? 7'h00 : crc_q, i_byte);
    else if (i_clear) crc_q <= 7'h00;
  end

  assign o_crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/sdspi_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module : sdspi_cmd_responder
// Desc   : Card-side SD SPI command framer and response serialiser. Frames
//          6-byte commands, checks CRC7, hands {cmd,arg} to the handler and
//          plays back R1/R1b/R3/R7 with Ncr filler and busy bytes.
// Rev    : 1.0 - initial release
// ============================================================================
module sdspi_cmd_responder
  import sdspi_cmd_responder_pkg::*;
#(
  parameter int unsigned NCR     = 1,
  parameter bit          OPT_CRC = 1'b1
)(
  input  logic                  i_clk,
  input  logic                  i_reset,
  sdspi_cmd_responder_if.slave  bus
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  ncr_q, ncr_d;
  logic        rsp_have_q, rsp_have_d;
  logic [1:0]  rsp_type_q, rsp_type_d;
  logic [7:0]  rsp_r1_q, rsp_r1_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [7:0]  ll_byte_q, ll_byte_d;
  logic        cmd_stb_q, cmd_stb_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;
  logic        crc_err_q, crc_err_d;
  logic        busy_q;

  logic [6:0]  crc7;
  logic        frame_start;
  logic        crc_bad;
  logic        rsp_ready;
  logic        r1_due;

  assign frame_start = (bus.i_ll_byte[7:6] == FRAME_START);
  assign crc_bad     = OPT_CRC && (bus.i_ll_byte != {crc7, 1'b1});
  // A response arriving in the same cycle as the deciding stb still counts
  assign rsp_ready   = rsp_have_q || bus.i_rsp_valid;
  assign r1_due      = (ncr_q <= 4'd1) && rsp_ready;

  sdspi_crc7_byte u_crc7 (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (state_q == ST_IDLE),
    .i_en    (bus.i_ll_stb && (((state_q == ST_IDLE) && frame_start) || (state_q == ST_ARG))),
    .i_byte  (bus.i_ll_byte),
    .o_crc   (crc7)
  );

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      ncr_q      <= 4'd0;
      rsp_have_q <= 1'b0;
      rsp_type_q <= RSP_R1;
      rsp_r1_q   <= 8'h00;
      rsp_data_q <= 32'h0;
      ll_byte_q  <= FILL_BYTE;
      cmd_stb_q  <= 1'b0;
      cmd_q      <= 6'd0;
      arg_q      <= 32'h0;
      crc_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ncr_q      <= ncr_d;
      rsp_have_q <= rsp_have_d;
      rsp_type_q <= rsp_type_d;
      rsp_r1_q   <= rsp_r1_d;
      rsp_data_q <= rsp_data_d;
      ll_byte_q  <= ll_byte_d;
      cmd_stb_q  <= cmd_stb_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      crc_err_q  <= crc_err_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  // Next-state decode; every move waits for a byte strobe
  always_comb begin
    state_d = state_q;
    if (bus.i_ll_stb) begin
      case (state_q)
        ST_IDLE: if (frame_start) state_d = ST_ARG;
        ST_ARG:  if (cnt_q == 3'd1) state_d = ST_CRC;
        ST_CRC:  state_d = ST_WAIT;
        ST_WAIT: if (r1_due) state_d = ST_R1;
        ST_R1: begin
          if (rsp_type_q[RSP_DATA_BIT])                     state_d = ST_DATA;
          else if ((rsp_type_q == RSP_R1B) && bus.i_busy_hold) state_d = ST_BUSY;
          else                                               state_d = ST_IDLE;
        end
        ST_DATA: if (cnt_q == 3'd0) state_d = ST_IDLE;
        ST_BUSY: if (!bus.i_busy_hold) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    cnt_d      = cnt_q;
    ncr_d      = ncr_q;
    rsp_have_d = rsp_have_q;
    rsp_type_d = rsp_type_q;
    rsp_r1_d   = rsp_r1_q;
    rsp_data_d = rsp_data_q;
    ll_byte_d  = ll_byte_q;
    cmd_stb_d  = 1'b0;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    crc_err_d  = crc_err_q;

    // Handler response is captured once per command, strobe or not
    if ((state_q == ST_WAIT) && !rsp_have_q && bus.i_rsp_valid) begin
      rsp_have_d = 1'b1;
      rsp_type_d = bus.i_rsp_type;
      rsp_r1_d   = bus.i_rsp_r1;
      rsp_data_d = bus.i_rsp_data;
    end

    if (bus.i_ll_stb) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            cmd_d = bus.i_ll_byte[5:0];
            cnt_d = 3'd4;
          end
        end
        ST_ARG: begin
          arg_d = {arg_q[23:0], bus.i_ll_byte};
          cnt_d = cnt_q - 3'd1;
        end
        ST_CRC: begin
          ll_byte_d  = FILL_BYTE;
          ncr_d      = 4'(NCR);
          cmd_stb_d  = !crc_bad;
          crc_err_d  = crc_bad;
          // A corrupted command is answered locally and never reaches the handler
          rsp_have_d = crc_bad;
          rsp_type_d = RSP_R1;
          rsp_r1_d   = R1_CRC_ERR;
        end
        ST_WAIT: begin
          if (ncr_q != 4'd0) ncr_d = ncr_q - 4'd1;
          if (r1_due) ll_byte_d = rsp_have_q ? rsp_r1_q : bus.i_rsp_r1;
        end
        ST_R1: begin
          if (rsp_type_q[RSP_DATA_BIT]) begin
            ll_byte_d  = rsp_data_q[31:24];
            rsp_data_d = {rsp_data_q[23:0], 8'h00};
            cnt_d      = 3'd3;
          end else if ((rsp_type_q == RSP_R1B) && bus.i_busy_hold) begin
            ll_byte_d = BUSY_BYTE;
          end else begin
            ll_byte_d = FILL_BYTE;
          end
        end
        ST_DATA: begin
          if (cnt_q != 3'd0) begin
            ll_byte_d  = rsp_data_q[31:24];
            rsp_data_d = {rsp_data_q[23:0], 8'h00};
            cnt_d      = cnt_q - 3'd1;
          end else begin
            ll_byte_d = FILL_BYTE;
          end
        end
        ST_BUSY: ll_byte_d = bus.i_busy_hold ? BUSY_BYTE : FILL_BYTE;
        default: ll_byte_d = FILL_BYTE;
      endcase
    end
  end

  assign bus.o_ll_byte     = ll_byte_q;
  assign bus.o_cmd_stb     = cmd_stb_q;
  assign bus.o_cmd         = cmd_q;
  assign bus.o_cmd_arg     = arg_q;
  assign bus.o_cmd_crc_err = crc_err_q;
  assign bus.o_busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sdspi_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_sdspi_cmd_responder
// Desc   : Directed bench for sdspi_cmd_responder. Two instances share one
//          stimulus: A (NCR=1, CRC checked) and B (NCR=2, CRC ignored).
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sdspi_cmd_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0;
  logic [7:0]  mosi = 8'hFF;
  logic        rsp_valid = 1'b0;
  logic [1:0]  rsp_type = 2'b00;
  logic [7:0]  rsp_r1 = 8'h00;
  logic [31:0] rsp_data = 32'h0;
  logic        busy_hold = 1'b0;

  always #5 clk = ~clk;

  sdspi_cmd_responder_if bus_a ();
  sdspi_cmd_responder_if bus_b ();

  assign bus_a.i_ll_stb = stb;       assign bus_b.i_ll_stb = stb;
  assign bus_a.i_ll_byte = mosi;     assign bus_b.i_ll_byte = mosi;
  assign bus_a.i_rsp_valid = rsp_valid; assign bus_b.i_rsp_valid = rsp_valid;
  assign bus_a.i_rsp_type = rsp_type;   assign bus_b.i_rsp_type = rsp_type;
  assign bus_a.i_rsp_r1 = rsp_r1;       assign bus_b.i_rsp_r1 = rsp_r1;
  assign bus_a.i_rsp_data = rsp_data;   assign bus_b.i_rsp_data = rsp_data;
  assign bus_a.i_busy_hold = busy_hold; assign bus_b.i_busy_hold = busy_hold;

  sdspi_cmd_responder #(.NCR(1), .OPT_CRC(1'b1)) dut_a (.i_clk(clk), .i_reset(rst), .bus(bus_a));
  sdspi_cmd_responder #(.NCR(2), .OPT_CRC(1'b0)) dut_b (.i_clk(clk), .i_reset(rst), .bus(bus_b));

  int vectors = 0;
  int errors  = 0;
  logic [7:0] miso_a, miso_b;
  logic       cs_a, cs_b, busy_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One SPI transfer: MISO is what the responder offered before the strobe
  task automatic xfer(input logic [7:0] b);
    @(negedge clk);
    miso_a = bus_a.o_ll_byte;
    miso_b = bus_b.o_ll_byte;
    stb  = 1'b1;
    mosi = b;
    @(negedge clk);
    stb    = 1'b0;
    cs_a   = bus_a.o_cmd_stb;
    cs_b   = bus_b.o_cmd_stb;
    busy_a = bus_a.o_busy;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic xa(input string tag, input logic [7:0] ea);
    xfer(8'hFF);
    chk(tag, miso_a, ea);
  endtask

  task automatic xab(input string tag, input logic [7:0] ea, input logic [7:0] eb);
    xfer(8'hFF);
    chk({tag, "_a"}, miso_a, ea);
    chk({tag, "_b"}, miso_b, eb);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    xfer({2'b01, idx});
    xfer(arg[31:24]);
    xfer(arg[23:16]);
    xfer(arg[15:8]);
    xfer(arg[7:0]);
    xfer(crc);
  endtask

  task automatic pulse_rsp(input logic [1:0] t, input logic [7:0] r1, input logic [31:0] d);
    @(negedge clk);
    rsp_type  = t;
    rsp_r1    = r1;
    rsp_data  = d;
    rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ll_byte", bus_a.o_ll_byte, 8'hFF);
    chk("rst_busy", bus_a.o_busy, 1'b0);
    chk("rst_cmd_stb", bus_a.o_cmd_stb, 1'b0);
    chk("rst_cmd", bus_a.o_cmd, 6'd0);
    chk("rst_arg", bus_a.o_cmd_arg, 32'h0);
    chk("rst_crc_err", bus_a.o_cmd_crc_err, 1'b0);

    // CMD0, R1 = 0x01
    send_cmd(6'd0, 32'h0, 8'h95);
    chk("c0_stb_a", cs_a, 1'b1);
    chk("c0_stb_b", cs_b, 1'b1);
    chk("c0_cmd", bus_a.o_cmd, 6'd0);
    chk("c0_arg", bus_a.o_cmd_arg, 32'h0);
    chk("c0_err", bus_a.o_cmd_crc_err, 1'b0);
    chk("c0_busy", bus_a.o_busy, 1'b1);
    pulse_rsp(2'b00, 8'h01, 32'h0);
    xab("c0_m0", 8'hFF, 8'hFF);
    xab("c0_m1", 8'h01, 8'hFF);
    xab("c0_m2", 8'hFF, 8'h01);
    xab("c0_m3", 8'hFF, 8'hFF);
    chk("c0_idle", bus_a.o_busy, 1'b0);

    // CMD8, R7
    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    chk("c8_stb", cs_a, 1'b1);
    chk("c8_cmd", bus_a.o_cmd, 6'd8);
    chk("c8_arg", bus_a.o_cmd_arg, 32'h0000_01AA);
    pulse_rsp(2'b10, 8'h01, 32'h0000_01AA);
    xab("c8_m0", 8'hFF, 8'hFF);
    xab("c8_m1", 8'h01, 8'hFF);
    xab("c8_m2", 8'h00, 8'h01);
    xab("c8_m3", 8'h00, 8'h00);
    xab("c8_m4", 8'h01, 8'h00);
    xab("c8_m5", 8'hAA, 8'h01);
    xab("c8_m6", 8'hFF, 8'hAA);
    xab("c8_m7", 8'hFF, 8'hFF);

    // CMD0 with a bad CRC: A answers 0x08, B (CRC ignored) takes handler R1
    send_cmd(6'd0, 32'h0, 8'h97);
    chk("bad_stb_a", cs_a, 1'b0);
    chk("bad_err_a", bus_a.o_cmd_crc_err, 1'b1);
    chk("bad_stb_b", cs_b, 1'b1);
    chk("bad_err_b", bus_b.o_cmd_crc_err, 1'b0);
    pulse_rsp(2'b00, 8'h01, 32'h0);
    xab("bad_m0", 8'hFF, 8'hFF);
    xab("bad_m1", 8'h08, 8'hFF);
    xab("bad_m2", 8'hFF, 8'h01);
    xab("bad_m3", 8'hFF, 8'hFF);

    // R1b with busy held for three transfers
    send_cmd(6'd0, 32'h0, 8'h95);
    chk("r1b_err", bus_a.o_cmd_crc_err, 1'b0);
    busy_hold = 1'b1;
    pulse_rsp(2'b01, 8'h00, 32'h0);
    xab("r1b_m0", 8'hFF, 8'hFF);
    xab("r1b_m1", 8'h00, 8'hFF);
    xab("r1b_m2", 8'h00, 8'h00);
    xab("r1b_m3", 8'h00, 8'h00);
    chk("r1b_busy_hi", busy_a, 1'b1);
    busy_hold = 1'b0;
    xab("r1b_m4", 8'h00, 8'h00);
    chk("r1b_busy_lo", busy_a, 1'b0);
    xab("r1b_m5", 8'hFF, 8'hFF);

    // Noise bytes in IDLE start nothing
    xfer(8'hFF);
    chk("noise_ff_busy", busy_a, 1'b0);
    xfer(8'h3F);
    chk("noise_3f_busy", busy_a, 1'b0);
    chk("noise_3f_cmd", bus_a.o_cmd, 6'd0);

    // CMD55, handler answers on the fifth WAIT transfer
    send_cmd(6'd55, 32'h0, 8'h65);
    chk("c55_stb", cs_a, 1'b1);
    chk("c55_cmd", bus_a.o_cmd, 6'd55);
    xab("dly_m0", 8'hFF, 8'hFF);
    xab("dly_m1", 8'hFF, 8'hFF);
    xab("dly_m2", 8'hFF, 8'hFF);
    xab("dly_m3", 8'hFF, 8'hFF);
    rsp_type  = 2'b00;
    rsp_r1    = 8'h05;
    rsp_valid = 1'b1;
    xab("dly_m4", 8'hFF, 8'hFF);
    rsp_valid = 1'b0;
    xab("dly_m5", 8'h05, 8'h05);
    xab("dly_m6", 8'hFF, 8'hFF);

    // Reset in the middle of an R7 payload
    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    pulse_rsp(2'b10, 8'h01, 32'h1234_5678);
    xa("rd_m0", 8'hFF);
    xa("rd_m1", 8'h01);
    xa("rd_m2", 8'h12);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rd_ll_byte", bus_a.o_ll_byte, 8'hFF);
    chk("rd_busy", bus_a.o_busy, 1'b0);
    chk("rd_arg", bus_a.o_cmd_arg, 32'h0);
    send_cmd(6'd0, 32'h0, 8'h95);
    chk("rd_c0_stb", cs_a, 1'b1);
    pulse_rsp(2'b00, 8'h01, 32'h0);
    xa("rd_c0_m0", 8'hFF);
    xa("rd_c0_m1", 8'h01);
    xa("rd_c0_m2", 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
